// File: rtl/lt24_frame_writer.sv
// LT24 frame writer: one header (column/page window when LT24_WINDOW_EN is defined, else RAMWR only) then H_RES x V_RES pixels with one filled box.
// Latency: first bus word on the cycle after start is accepted, 2 cycles per word, finish_flag on cycle 2W+1.
// Backpressure: none; the write-only LCD bus never stalls and start is ignored while a frame is in flight.
module lt24_frame_writer #(
    parameter int H_RES = 240,
    parameter int V_RES = 320,
    parameter int BOX   = 32
) (
    input  logic        clock_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [11:0] pattern,
    input  logic [31:0] vx,
    input  logic [31:0] vy,
    output logic        finish_flag,
    output logic [31:0] counter,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data
);

    typedef enum logic [1:0] {IDLE, HDR, PIX, DONE} state_t;

    typedef struct packed {
        logic        rs;
        logic [15:0] dat;
    } word_t;

    typedef struct packed {
        logic [11:0] pattern;
        logic [8:0]  bx;
        logic [8:0]  by;
    } cfg_t;

`ifdef LT24_WINDOW_EN
    localparam int HDR_LEN = 11;
`else
    localparam int HDR_LEN = 1;
`endif

    localparam logic [15:0] H_LAST  = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST  = 16'(V_RES - 1);
    localparam logic [3:0]  HDR_END = 4'(HDR_LEN - 1);
    localparam logic [8:0]  X_END   = 9'(H_RES - 1);
    localparam logic [8:0]  Y_END   = 9'(V_RES - 1);
    localparam logic [9:0]  BOX_W   = 10'(BOX);

    function automatic word_t hdr_word(input logic [3:0] idx);
        hdr_word = '{rs: 1'b1, dat: 16'h0000};
`ifdef LT24_WINDOW_EN
        case (idx)
            4'd0:    hdr_word = '{rs: 1'b0, dat: 16'h002A};
            4'd3:    hdr_word = '{rs: 1'b1, dat: {8'h00, H_LAST[15:8]}};
            4'd4:    hdr_word = '{rs: 1'b1, dat: {8'h00, H_LAST[7:0]}};
            4'd5:    hdr_word = '{rs: 1'b0, dat: 16'h002B};
            4'd8:    hdr_word = '{rs: 1'b1, dat: {8'h00, V_LAST[15:8]}};
            4'd9:    hdr_word = '{rs: 1'b1, dat: {8'h00, V_LAST[7:0]}};
            4'd10:   hdr_word = '{rs: 1'b0, dat: 16'h002C};
            default: hdr_word = '{rs: 1'b1, dat: 16'h0000};
        endcase
`else
        case (idx)
            default: hdr_word = '{rs: 1'b0, dat: 16'h002C};
        endcase
`endif
    endfunction

    // Box bounds use 10-bit sums so a box near x/y = 511 clips instead of wrapping.
    function automatic word_t pix_word(input logic [8:0] x, input logic [8:0] y, input cfg_t c);
        logic       in_x;
        logic       in_y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        in_x = ({1'b0, x} >= {1'b0, c.bx}) && ({1'b0, x} < ({1'b0, c.bx} + BOX_W));
        in_y = ({1'b0, y} >= {1'b0, c.by}) && ({1'b0, y} < ({1'b0, c.by} + BOX_W));
        r = c.pattern[11:8];
        g = c.pattern[7:4];
        b = c.pattern[3:0];
        pix_word.rs  = 1'b1;
        pix_word.dat = (in_x && in_y) ? {r, r[3], g, g[3:2], b, b[3]} : 16'h0000;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state_q, state_d;
    logic        ph_q, ph_d;
    logic [3:0]  hidx_q, hidx_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic [8:0]  nx, ny;
    cfg_t        cfg_q, cfg_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] counter_q, counter_d;
    logic        finish_q, finish_d;
    logic        cs_n_q, cs_n_d;
    logic        wr_n_q, wr_n_d;
    word_t       word_q, word_d;
    logic        unused_hi;

    assign unused_hi = ^{vx[31:9], vy[31:9]};

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            state_q   <= IDLE;
            ph_q      <= 1'b0;
            hidx_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            cfg_q     <= '0;
            cnt_q     <= '0;
            counter_q <= '0;
            finish_q  <= 1'b0;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            word_q    <= '{rs: 1'b1, dat: 16'h0000};
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            hidx_q    <= hidx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            counter_q <= counter_d;
            finish_q  <= finish_d;
            cs_n_q    <= cs_n_d;
            wr_n_q    <= wr_n_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        hidx_d    = hidx_q;
        x_d       = x_q;
        y_d       = y_q;
        cfg_d     = cfg_q;
        cnt_d     = sat_inc(cnt_q);
        counter_d = counter_q;
        finish_d  = finish_q;
        cs_n_d    = cs_n_q;
        wr_n_d    = wr_n_q;
        word_d    = word_q;
        nx        = (x_q == X_END) ? 9'd0 : x_q + 9'd1;
        ny        = (x_q == X_END) ? y_q + 9'd1 : y_q;

        case (state_q)
            IDLE, DONE: begin
                cnt_d = cnt_q;
                if (start) begin
                    cfg_d    = '{pattern: pattern, bx: vx[8:0], by: vy[8:0]};
                    finish_d = 1'b0;
                    cnt_d    = 32'd1;
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    word_d   = hdr_word(4'd0);
                    hidx_d   = 4'd0;
                    ph_d     = 1'b0;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (!ph_q) begin
                    ph_d   = 1'b1;
                    wr_n_d = 1'b1;
                end else if (hidx_q == HDR_END) begin
                    x_d     = 9'd0;
                    y_d     = 9'd0;
                    word_d  = pix_word(9'd0, 9'd0, cfg_q);
                    ph_d    = 1'b0;
                    wr_n_d  = 1'b0;
                    state_d = PIX;
                end else begin
                    hidx_d = hidx_q + 4'd1;
                    word_d = hdr_word(hidx_q + 4'd1);
                    ph_d   = 1'b0;
                    wr_n_d = 1'b0;
                end
            end
            PIX: begin
                if (!ph_q) begin
                    ph_d   = 1'b1;
                    wr_n_d = 1'b1;
                end else if (x_q == X_END && y_q == Y_END) begin
                    cs_n_d    = 1'b1;
                    finish_d  = 1'b1;
                    counter_d = cnt_d;
                    ph_d      = 1'b0;
                    state_d   = DONE;
                end else begin
                    x_d    = nx;
                    y_d    = ny;
                    word_d = pix_word(nx, ny, cfg_q);
                    ph_d   = 1'b0;
                    wr_n_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign finish_flag = finish_q;
    assign counter     = counter_q;
    assign lcd_cs_n    = cs_n_q;
    assign lcd_wr_n    = wr_n_q;
    assign lcd_rs      = word_q.rs;
    assign lcd_data    = word_q.dat;
    assign lcd_rd_n    = 1'b1;

endmodule

// File: tb/tb_lt24_frame_writer.sv
// Bench for lt24_frame_writer on a reduced 24x24 panel; bus words are captured and compared to a
// word list built directly from the frame rules (header, raster order, box test, RGB565 expansion).
module tb_lt24_frame_writer;
    localparam int H  = 24;
    localparam int V  = 24;
    localparam int BX = 5;
`ifdef LT24_WINDOW_EN
    localparam int HL   = 11;
    localparam int HDR0 = 32'h2A;
`else
    localparam int HL   = 1;
    localparam int HDR0 = 32'h2C;
`endif

    logic        clock_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] pattern = '0;
    logic [31:0] vx = '0;
    logic [31:0] vy = '0;
    logic        finish_flag;
    logic [31:0] counter;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0] lcd_data;

    lt24_frame_writer #(.H_RES(H), .V_RES(V), .BOX(BX)) dut (
        .clock_clk(clock_clk), .reset_reset_n(reset_reset_n), .start(start),
        .pattern(pattern), .vx(vx), .vy(vy), .finish_flag(finish_flag), .counter(counter),
        .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n),
        .lcd_data(lcd_data)
    );

    always #5 clock_clk = ~clock_clk;

    int checks = 0;
    int errors = 0;
    int got[$];
    int exp_q[$];
    int fin_cyc;

    // each word has exactly one wr_n-low cycle
    always @(negedge clock_clk)
        if (!lcd_wr_n && !lcd_cs_n) got.push_back(int'({lcd_rs, lcd_data}));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int got_at(input int i);
        return (i < got.size()) ? got[i] : -1;
    endfunction

    function automatic int rgb565(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        return (r << 12) | ((r >> 3) << 11) | (g << 7) | ((g >> 2) << 5) | (b << 1) | (b >> 3);
    endfunction

    task automatic build_model(input logic [11:0] p, input logic [31:0] x32, input logic [31:0] y32);
        int bx, by;
        bx = int'(x32 % 512);
        by = int'(y32 % 512);
        exp_q.delete();
`ifdef LT24_WINDOW_EN
        exp_q.push_back(32'h2A);
        exp_q.push_back(32'h10000);
        exp_q.push_back(32'h10000);
        exp_q.push_back(32'h10000 | ((H - 1) / 256));
        exp_q.push_back(32'h10000 | ((H - 1) % 256));
        exp_q.push_back(32'h2B);
        exp_q.push_back(32'h10000);
        exp_q.push_back(32'h10000);
        exp_q.push_back(32'h10000 | ((V - 1) / 256));
        exp_q.push_back(32'h10000 | ((V - 1) % 256));
        exp_q.push_back(32'h2C);
`else
        exp_q.push_back(32'h2C);
`endif
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (x >= bx && x < bx + BX && y >= by && y < by + BX)
                    exp_q.push_back(32'h10000 | rgb565(p));
                else
                    exp_q.push_back(32'h10000);
    endtask

    task automatic run_frame(input logic [11:0] p, input logic [31:0] x, input logic [31:0] y,
                             input bit disturb, input int abort_at);
        int bad;
        build_model(p, x, y);
        got.delete();
        pattern = p;
        vx = x;
        vy = y;
        start = 1'b1;
        @(posedge clock_clk);
        #1;
        start = 1'b0;
        chk("first_wr_n", lcd_wr_n, 0);
        chk("first_cs_n", lcd_cs_n, 0);
        fin_cyc = -1;
        for (int c = 1; c <= 2 * exp_q.size() + 20; c++) begin
            @(negedge clock_clk);
            if (finish_flag) begin
                fin_cyc = c;
                break;
            end
            if (abort_at != 0 && c == abort_at) begin
                reset_reset_n = 1'b0;
                return;
            end
            if (disturb) begin
                start   = 1'($urandom_range(0, 1));
                pattern = 12'($urandom);
                vx      = $urandom;
                vy      = $urandom;
            end
        end
        start = 1'b0;
        chk("finish_cycle", fin_cyc, 2 * exp_q.size() + 1);
        chk("counter", counter, 2 * exp_q.size() + 1);
        chk("word_count", got.size(), exp_q.size());
        chk("hdr0", got_at(0), HDR0);
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (got_at(i) != exp_q[i]) bad++;
        chk("word_mismatches", bad, 0);
        chk("cs_n_done", lcd_cs_n, 1);
    endtask

    initial begin
        int yy;
        int cnt_hold;
        repeat (3) @(posedge clock_clk);
        #1;
        chk("rst_finish", finish_flag, 0);
        chk("rst_counter", counter, 0);
        chk("rst_cs_n", lcd_cs_n, 1);
        chk("rst_wr_n", lcd_wr_n, 1);
        chk("rst_rs", lcd_rs, 1);
        chk("rst_rd_n", lcd_rd_n, 1);
        chk("rst_data", lcd_data, 0);
        @(negedge clock_clk);
        reset_reset_n = 1'b1;
        @(negedge clock_clk);

        // magenta box at (1,1)
        run_frame(12'hF0F, 32'd1, 32'd1, 1'b0, 0);
        chk("px_0_0", got_at(HL), 32'h10000);
        chk("px_1_1", got_at(HL + H + 1), 32'h1F81F);
        chk("px_0_1", got_at(HL + H), 32'h10000);

        run_frame(12'($urandom), 32'($urandom_range(0, H - 1)), 32'($urandom_range(0, V - 1)), 1'b0, 0);

        // box at the right edge must clip, not wrap to x=0
        yy = $urandom_range(0, V - BX);
        run_frame(12'h0F0, 32'(H - 1), 32'(yy), 1'b0, 0);
        chk("edge_last_x", got_at(HL + yy * H + H - 1), 32'h107E0);
        chk("edge_no_wrap", got_at(HL + yy * H), 32'h10000);

        // upper address bits ignored
        run_frame(12'($urandom), 32'hFFFF_FE03, 32'h8000_0004, 1'b0, 0);
        run_frame(12'($urandom), 32'd0, 32'(V - 2), 1'b0, 0);

        cnt_hold = 2 * exp_q.size() + 1;
        repeat (20) @(negedge clock_clk);
        chk("done_finish", finish_flag, 1);
        chk("done_counter", counter, cnt_hold);
        chk("done_cs_n", lcd_cs_n, 1);

        run_frame(12'($urandom), 32'($urandom_range(0, H - 1)), 32'($urandom_range(0, V - 1)), 1'b1, 0);
        repeat (5) @(negedge clock_clk);
        chk("single_frame", finish_flag, 1);

        run_frame(12'($urandom), 32'd3, 32'd3, 1'b0, 1000);
        @(posedge clock_clk);
        #1;
        chk("abort_cs_n", lcd_cs_n, 1);
        chk("abort_wr_n", lcd_wr_n, 1);
        chk("abort_finish", finish_flag, 0);
        chk("abort_counter", counter, 0);
        start = 1'b1;
        repeat (2) @(negedge clock_clk);
        chk("abort_finish_held", finish_flag, 0);
        reset_reset_n = 1'b1;
        run_frame(12'($urandom), 32'($urandom_range(0, H - 1)), 32'($urandom_range(0, V - 1)), 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
